ddsm_ratio_decoder: RTL and testbench

- Decoder for the third-order MASH DDSM control stream driven into the integer divider.
- Captures the signed 4-bit per-cycle divide offset over a window of 2^WIN_LOG2 samples, adds back the integer divide word, and reports the recovered average divide ratio in Q8.16.
- Sits beside the fractional divider on the mod_clk (divided clock) domain. Used for built-in self-check of divider_integer/divider_fraction programming and for bench-side ratio recovery.

---
 rtl/ddsm_ratio_decoder.sv | 151 +++++++++++++++
 tb/tb_ddsm_ratio_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ddsm_ratio_decoder.sv
// ddsm_ratio_decoder
//   Recovers the average divide ratio (unsigned Q8.16) from the MASH DDSM
//   offset stream feeding the integer divider. It sums 2^WIN_LOG2 signed
//   4-bit offsets, adds back integer*2^WIN_LOG2 and scales the result to Q8.16.
//   Optional feature: define DDSM_RATIO_DECODER_MINMAX_EN to add the
//   ctrl_min / ctrl_max window statistics outputs.
//   Reset: rst_n is synchronous and active-low. All logic runs on mod_clk.
module ddsm_ratio_decoder #(
  parameter int WIN_LOG2 = 16
) (
  input  logic        mod_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  div_integer,
  input  logic [3:0]  ctrl_in,
  input  logic        ctrl_valid,
  output logic        busy,
  output logic        done,
  output logic [23:0] ratio_out,
  output logic        range_err,
  output logic        ctrl_err
`ifdef DDSM_RATIO_DECODER_MINMAX_EN
  ,
  output logic signed [3:0] ctrl_min,
  output logic signed [3:0] ctrl_max
`endif
);

  localparam int WA = WIN_LOG2 + 5;   // accumulator, |sum| <= 8*2^WIN_LOG2
  localparam int WT = WIN_LOG2 + 10;  // integer*2^WIN_LOG2 + sum, signed
  localparam int SH = 16 - WIN_LOG2;  // scale window sum to 16 fraction bits

  localparam logic signed [3:0] OFS_LO = -4'sd3;
  localparam logic signed [3:0] OFS_HI = 4'sd4;

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

  state_t                state_q, state_d;
  logic [7:0]            int_q;
  logic signed [WA-1:0]  acc_q;
  logic [WIN_LOG2-1:0]   cnt_q;
  logic                  werr_q;

  logic                  take, last, bad;
  logic signed [3:0]     ofs;
  logic [WA-1:0]         ofs_ext;
  logic [WT-1:0]         total;
  logic [WIN_LOG2+7:0]   mag;
  logic [23:0]           ratio_calc;

  assign ofs     = $signed(ctrl_in);
  assign take    = (state_q == ACCUM) && ctrl_valid;
  assign last    = &cnt_q;
  // Out-of-range samples are flagged but still summed.
  assign bad     = (ofs < OFS_LO) || (ofs > OFS_HI);
  assign ofs_ext = {{(WIN_LOG2 + 1){ctrl_in[3]}}, ctrl_in};

  // Bits above WIN_LOG2+8 only carry the sign, so the magnitude fits in
  // WIN_LOG2+8 bits whenever the result is in range.
  assign total      = {2'b00, int_q, {WIN_LOG2{1'b0}}} + {{5{acc_q[WA-1]}}, acc_q};
  assign mag        = total[WIN_LOG2+7:0];
  assign ratio_calc = 24'(mag) << SH;

  assign busy = (state_q != IDLE);

`ifdef DDSM_RATIO_DECODER_MINMAX_EN
  logic signed [3:0] wmin_q, wmax_q;
  logic              first;
  assign first = (cnt_q == '0);
`endif

  // State register
  always_ff @(posedge mod_clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: start only in IDLE; leave ACCUM on the 2^WIN_LOG2-th sample
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (take && last) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window datapath and result publication (done rises with the new results)
  always_ff @(posedge mod_clk) begin
    if (!rst_n) begin
      int_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      werr_q    <= 1'b0;
      done      <= 1'b0;
      ratio_out <= '0;
      range_err <= 1'b0;
      ctrl_err  <= 1'b0;
`ifdef DDSM_RATIO_DECODER_MINMAX_EN
      wmin_q    <= '0;
      wmax_q    <= '0;
      ctrl_min  <= '0;
      ctrl_max  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            int_q  <= div_integer;
            acc_q  <= '0;
            cnt_q  <= '0;
            werr_q <= 1'b0;
          end
        end
        ACCUM: begin
          if (ctrl_valid) begin
            acc_q <= acc_q + ofs_ext;
            cnt_q <= cnt_q + WIN_LOG2'(1);
            if (bad) werr_q <= 1'b1;
`ifdef DDSM_RATIO_DECODER_MINMAX_EN
            if (first || ofs < wmin_q) wmin_q <= ofs;
            if (first || ofs > wmax_q) wmax_q <= ofs;
`endif
          end
        end
        FINISH: begin
          done     <= 1'b1;
          ctrl_err <= werr_q;
          if (total[WT-1]) begin
            ratio_out <= '0;
            range_err <= 1'b1;
          end else if (total[WIN_LOG2+8]) begin
            ratio_out <= 24'hFFFFFF;
            range_err <= 1'b1;
          end else begin
            ratio_out <= ratio_calc;
            range_err <= 1'b0;
          end
`ifdef DDSM_RATIO_DECODER_MINMAX_EN
          ctrl_min <= wmin_q;
          ctrl_max <= wmax_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddsm_ratio_decoder.sv
// tb_ddsm_ratio_decoder
//   Randomized + directed windows on a WIN_LOG2=4 decoder. The expected
//   results come from plain integer arithmetic over the sample list.
module tb_ddsm_ratio_decoder;

  localparam int WL = 4;
  localparam int N  = 1 << WL;

  logic        mod_clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  div_integer;
  logic [3:0]  ctrl_in;
  logic        ctrl_valid;
  logic        busy, done, range_err, ctrl_err;
  logic [23:0] ratio_out;
`ifdef DDSM_RATIO_DECODER_MINMAX_EN
  logic signed [3:0] ctrl_min, ctrl_max;
`endif

  int n_chk = 0;
  int n_bad = 0;
  int smp[N];

  ddsm_ratio_decoder #(.WIN_LOG2(WL)) dut (
    .mod_clk     (mod_clk),
    .rst_n       (rst_n),
    .start       (start),
    .div_integer (div_integer),
    .ctrl_in     (ctrl_in),
    .ctrl_valid  (ctrl_valid),
    .busy        (busy),
    .done        (done),
    .ratio_out   (ratio_out),
    .range_err   (range_err),
    .ctrl_err    (ctrl_err)
`ifdef DDSM_RATIO_DECODER_MINMAX_EN
    ,
    .ctrl_min    (ctrl_min),
    .ctrl_max    (ctrl_max)
`endif
  );

  initial mod_clk = 1'b0;
  always #5 mod_clk = ~mod_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full window: model first, then drive with optional gaps. Inputs
  // change on negedge; outputs are observed on negedge.
  task automatic run_window(input int ival, input bit gaps, input string tag);
    int          sum;
    bit          e_cerr, e_rerr;
    logic [23:0] e_ratio;
    int          mn, mx;
    logic [7:0]  iv;
    logic [3:0]  s4;
    sum = ival * N;
    e_cerr = 1'b0;
    mn = smp[0];
    mx = smp[0];
    foreach (smp[i]) begin
      sum += smp[i];
      if (smp[i] < -3 || smp[i] > 4) e_cerr = 1'b1;
      if (smp[i] < mn) mn = smp[i];
      if (smp[i] > mx) mx = smp[i];
    end
    if (sum < 0) begin
      e_ratio = 24'h0; e_rerr = 1'b1;
    end else if (sum >= 256 * N) begin
      e_ratio = 24'hFFFFFF; e_rerr = 1'b1;
    end else begin
      e_ratio = 24'(sum * (65536 / N)); e_rerr = 1'b0;
    end

    iv = ival[7:0];
    start       = 1'b1;
    div_integer = iv;
    ctrl_valid  = 1'b1;           // ignored while IDLE
    ctrl_in     = 4'd7;
    @(negedge mod_clk);
    start = 1'b0;
    chk({tag, "_busy_go"}, busy, 1);
    div_integer = 8'($urandom);   // only the value at start matters
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          ctrl_valid = 1'b0;
          ctrl_in    = 4'($urandom);
          start      = 1'($urandom);
          @(negedge mod_clk);
          chk({tag, "_busy_gap"}, busy, 1);
          chk({tag, "_done_gap"}, done, 0);
        end
      end
      s4 = smp[i][3:0];
      ctrl_valid = 1'b1;
      ctrl_in    = s4;
      start      = 1'($urandom);
      @(negedge mod_clk);
    end
    // FINISH cycle: still busy, no done yet, start must be ignored
    ctrl_valid = 1'b0;
    start      = 1'b1;
    chk({tag, "_busy_fin"}, busy, 1);
    chk({tag, "_done_early"}, done, 0);
    @(negedge mod_clk);
    start = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_ratio"}, ratio_out, e_ratio);
    chk({tag, "_range_err"}, range_err, e_rerr);
    chk({tag, "_ctrl_err"}, ctrl_err, e_cerr);
`ifdef DDSM_RATIO_DECODER_MINMAX_EN
    chk({tag, "_min"}, {28'd0, ctrl_min}, 32'(mn[3:0]));
    chk({tag, "_max"}, {28'd0, ctrl_max}, 32'(mx[3:0]));
`endif
    @(negedge mod_clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_hold"}, ratio_out, e_ratio);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; div_integer = 8'd99; ctrl_in = 4'd3; ctrl_valid = 1'b1;
    repeat (2) @(negedge mod_clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ratio", ratio_out, 0);
    chk("rst_range", range_err, 0);
    chk("rst_cerr", ctrl_err, 0);
    start = 1'b0; ctrl_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge mod_clk);
    chk("idle_busy", busy, 0);

    foreach (smp[i]) smp[i] = 1;
    run_window(10, 1'b0, "ones");

    foreach (smp[i]) smp[i] = i % 2;
    run_window(10, 1'b1, "alt_gaps");

    foreach (smp[i]) smp[i] = -1;
    run_window(0, 1'b0, "under");

    foreach (smp[i]) smp[i] = 4;
    run_window(255, 1'b0, "over");

    foreach (smp[i]) smp[i] = (i == 3) ? -8 : 0;
    run_window(20, 1'b0, "bad_smp");

    // Abandon a window with reset partway through.
    start = 1'b1; div_integer = 8'd9;
    @(negedge mod_clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ctrl_valid = 1'b1; ctrl_in = 4'd3;
      @(negedge mod_clk);
      chk("abort_done", done, 0);
    end
    rst_n = 1'b0; ctrl_valid = 1'b0;
    @(negedge mod_clk);
    chk("abort_busy", busy, 0);
    chk("abort_done_rst", done, 0);
    chk("abort_ratio", ratio_out, 0);
    chk("abort_cerr", ctrl_err, 0);
    rst_n = 1'b1;
    @(negedge mod_clk);
    chk("abort_no_done", done, 0);
    foreach (smp[i]) smp[i] = 0;
    run_window(5, 1'b0, "after_rst");

    // Range edges.
    foreach (smp[i]) smp[i] = (i == 0) ? 0 : 1;
    run_window(255, 1'b0, "top_in");
    foreach (smp[i]) smp[i] = 1;
    run_window(255, 1'b0, "top_sat");
    foreach (smp[i]) smp[i] = 0;
    run_window(0, 1'b0, "zero");
    foreach (smp[i]) smp[i] = (i == 5) ? -1 : 0;
    run_window(0, 1'b0, "neg_one");

    // Random windows, occasionally with out-of-range offsets.
    for (int w = 0; w < 24; w++) begin
      foreach (smp[i])
        smp[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) - 8
                                              : int'($urandom_range(0, 7)) - 3;
      run_window(int'($urandom_range(0, 255)), 1'($urandom), "rnd");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
